histogram_cdf_builder: RTL and testbench
========================================

// Module: histogram_cdf_builder
// PURPOSE
// - Producer side of histogram equalisation: bins one frame of 8-bit pixels, then builds the CDF.
// - Serves CDF lookups, cdf_min and total_pixels to the downstream equaliser.
// - Sits in parallel with the equaliser on the video stream; frame N's CDF is used for frame N+1.
// PARAMETERS
// - COUNT_W   32   bin/CDF counter width; must hold the max pixels per frame
// - PIX_W     8    pixel width; bins = 2**PIX_W (256)
// PORTS
// - clk           in   1        clock
// - reset         in   1        reset, asynchronous, active-high
// - pix_in        in   PIX_W    pixel value to bin
// - pix_valid     in   1        pix_in qualifier; accepted only when pix_ready=1
// - pix_eof       in   1        with pix_valid: last pixel of frame (that pixel is counted)
// - pix_ready     out  1        1 in ACCUM only
// - lut_rd        in   1        CDF lookup strobe
// - lut_addr      in   PIX_W    bin to look up
// - cdf_data      out  COUNT_W  CDF[lut_addr], 1-cycle latency
// - cdf_data_vld  out  1        lut_rd delayed 1 cycle
// - cdf_min       out  COUNT_W  first non-zero CDF value of last completed frame
// - total_pixels  out  COUNT_W  pixels counted in last completed frame (= CDF[255])
// - cdf_valid     out  1        CDF RAM/cdf_min/total_pixels coherent; 0 during SCAN and before first scan
// - frame_done    out  1        1-cycle pulse when SCAN completes
// - overflow      out  1        sticky: some bin saturated; cleared by reset only
// BEHAVIOUR
// - Reset: pix_ready=0, cdf_data=0, cdf_data_vld=0, cdf_min=0, total_pixels=0, cdf_valid=0,
//   frame_done=0, overflow=0; FSM -> CLEAR.
// - FSM CLEAR: 2**PIX_W cycles write 0 to every hist bin (addr 0..255) -> ACCUM.
// - FSM ACCUM: pix_ready=1; each accepted pixel does hist[p]++ via 2-stage RMW (read, add+write).
// - ACCUM -> DRAIN on accepted pix_eof; pix_ready=0 from the next cycle.
// - FSM DRAIN: 2 cycles, lets RMW pipe empty -> SCAN.
// - FSM SCAN: addr 0..255, one bin/cycle; running sum acc += hist[i]; cdf[i] <= acc; hist[i] <= 0.
//   cdf_min latches the first non-zero acc (0 if frame empty); total_pixels <= final acc.
//   Last bin: frame_done pulse, cdf_valid <= 1 -> ACCUM. No separate CLEAR needed after frame 1.
// - cdf_valid drops to 0 on SCAN entry; pixels offered in DRAIN/SCAN/CLEAR are not accepted.
// - RMW hazard: same bin on consecutive cycles, or 1 cycle apart, must forward the in-flight
//   count; every accepted pixel is counted exactly once.
// - Arithmetic: bin increment saturates at 2**COUNT_W-1 and sets overflow.
//   The scan sum saturates the same way and sets overflow.
// - Lookup port is independent of the FSM; reads in any state return current CDF RAM contents.
// - Reads during SCAN may be mixed old/new; consumers qualify with cdf_valid.
// - Reset mid-operation: all state discarded, CLEAR restarts; cdf_valid stays 0 until the next scan.
// STRUCTURE
// - Shared pkg: PIX_W, COUNT_W defaults, NUM_BINS = 2**PIX_W, FSM state encoding
//   (CLEAR, ACCUM, DRAIN, SCAN).
// - One sub-module: hist_ram_dp, a simple dual-port RAM (1 write, 1 read, 1-cycle read latency).
//   Instantiated twice: histogram RAM and CDF RAM.
// - Top holds the FSM, RMW pipe + forwarding, scan accumulator, and the output registers.
// TESTING
// - Reset, then wait: pix_ready=0 for 256 cycles, then 1; cdf_valid=0, all outputs 0.
// - Frame of 4 px {10,10,20,255} with eof on 255 -> after SCAN: cdf[9]=0, cdf[10]=2,
//   cdf[20]=3, cdf[255]=4, cdf_min=2, total_pixels=4, one frame_done pulse.
// - 1000 back-to-back px all =7, then alternating 7,8,7,8 (10 px) -> cdf[7]=1005, cdf[8]=1010,
//   total=1010 (forwarding check).
// - pix_valid held high through DRAIN/SCAN -> pix_ready=0, no counts added.
//   Next frame {0} -> cdf_min=1, total_pixels=1, and all bins from the prior frame are cleared.
// - COUNT_W=4: 20 px =3 -> overflow=1, cdf[3]=15, total_pixels=15.
// - Assert reset at scan addr 100 -> outputs back to reset values; full CLEAR (256 cycles)
//   precedes ACCUM; a new frame then gives a correct CDF.

Source files
------------

// File: rtl/histogram_cdf_builder_pkg.sv
// Shared definitions for the histogram/CDF builder.
// Holds the default widths, the bin count and the controller state encoding.
package histogram_cdf_builder_pkg;

    localparam int PIX_W_DEF    = 8;
    localparam int COUNT_W_DEF  = 32;
    localparam int NUM_BINS_DEF = 2 ** PIX_W_DEF;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_SCAN  = 2'd3
    } state_e;

endpackage

// File: rtl/histogram_cdf_builder_hist_ram_dp.sv
// Simple dual-port RAM: one write port, one read port with a registered
// (1-cycle latency) read. A read and a write to the same address on the same
// edge return the old contents.
//   clk, reset       clock, async active-high reset (clears the read register only)
//   we_i/waddr_i/wdata_i   write port
//   re_i/raddr_i     read strobe and address; rdata_o holds the last read value
//   rdata_o          read data
module hist_ram_dp
    import histogram_cdf_builder_pkg::*;
#(
    parameter int DATA_W = COUNT_W_DEF,
    parameter int ADDR_W = PIX_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/histogram_cdf_builder.sv
// Histogram/CDF builder: bins one frame of pixels into a histogram RAM, then
// scans it into a CDF RAM that the downstream equaliser looks up while the
// next frame is being binned.
//   clk, reset                  clock, async active-high reset
//   pix_in/pix_valid/pix_eof    pixel stream, accepted when pix_ready=1
//   pix_ready                   high only while accumulating
//   lut_rd/lut_addr             CDF lookup; cdf_data/cdf_data_vld one cycle later
//   cdf_min/total_pixels        first non-zero CDF value / pixel count of last frame
//   cdf_valid                   CDF RAM and summary values are coherent
//   frame_done                  one-cycle pulse when a scan completes
//   overflow                    sticky saturation flag
//
// state | meaning
// CLEAR | zero every histogram bin, one per cycle (after reset only)
// ACCUM | accept pixels, read-modify-write hist[p]++
// DRAIN | two idle cycles so the last increment lands
// SCAN  | hist -> running sum -> CDF RAM, zeroing each bin behind the read
module histogram_cdf_builder
    import histogram_cdf_builder_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEF,
    parameter int PIX_W   = PIX_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic               pix_valid,
    input  logic               pix_eof,
    output logic               pix_ready,
    input  logic               lut_rd,
    input  logic [PIX_W-1:0]   lut_addr,
    output logic [COUNT_W-1:0] cdf_data,
    output logic               cdf_data_vld,
    output logic [COUNT_W-1:0] cdf_min,
    output logic [COUNT_W-1:0] total_pixels,
    output logic               cdf_valid,
    output logic               frame_done,
    output logic               overflow
);

    localparam int                 NUM_BINS      = 2 ** PIX_W;
    localparam int                 CNT_W         = PIX_W + 1;
    localparam logic [CNT_W-1:0]   CNT_LAST_BIN  = CNT_W'(NUM_BINS - 1);
    localparam logic [CNT_W-1:0]   CNT_SCAN_END  = CNT_W'(NUM_BINS);
    localparam logic [CNT_W-1:0]   CNT_DRAIN_END = CNT_W'(1);
    localparam logic [COUNT_W-1:0] COUNT_MAX     = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic pix_acc;

    assign pix_ready = (state_q == ST_ACCUM);
    assign pix_acc   = pix_valid & pix_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == CNT_LAST_BIN) begin
                    state_d = ST_ACCUM;
                    cnt_d   = '0;
                end
            end
            ST_ACCUM: begin
                cnt_d = '0;
                if (pix_acc && pix_eof) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_DRAIN_END) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                end
            end
            ST_SCAN: begin
                // One extra cycle past the last read so bin NUM_BINS-1 is summed
                // before pixels of the next frame can touch the histogram.
                if (cnt_q == CNT_SCAN_END) begin
                    state_d = ST_ACCUM;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // RAM ports
    logic               hist_we, hist_re;
    logic [PIX_W-1:0]   hist_waddr, hist_raddr;
    logic [COUNT_W-1:0] hist_wdata, hist_rdata;

    hist_ram_dp #(.DATA_W(COUNT_W), .ADDR_W(PIX_W)) u_hist_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (hist_we),
        .waddr_i (hist_waddr),
        .wdata_i (hist_wdata),
        .re_i    (hist_re),
        .raddr_i (hist_raddr),
        .rdata_o (hist_rdata)
    );

    logic               scan_issue, scan_stage, scan_last, scan_enter;
    logic [PIX_W-1:0]   scan_bin;
    logic [COUNT_W:0]   scan_sum_wide;
    logic [COUNT_W-1:0] scan_sum;
    logic [COUNT_W-1:0] acc_q;

    hist_ram_dp #(.DATA_W(COUNT_W), .ADDR_W(PIX_W)) u_cdf_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (scan_stage),
        .waddr_i (scan_bin),
        .wdata_i (scan_sum),
        .re_i    (lut_rd),
        .raddr_i (lut_addr),
        .rdata_o (cdf_data)
    );

    // RMW pipe: stage 0 issues the read, stage 1 adds and writes back.
    // Only back-to-back hits need forwarding: a hit one cycle apart has
    // already been written before the younger read is sampled.
    logic               rmw_vld_q;
    logic [PIX_W-1:0]   rmw_addr_q;
    logic               fwd_vld_q;
    logic [PIX_W-1:0]   fwd_addr_q;
    logic [COUNT_W-1:0] fwd_data_q;
    logic [COUNT_W-1:0] rmw_old, rmw_new;
    logic               rmw_sat;

    always_comb begin
        rmw_old = hist_rdata;
        if (fwd_vld_q && (fwd_addr_q == rmw_addr_q)) begin
            rmw_old = fwd_data_q;
        end
        rmw_sat = (rmw_old == COUNT_MAX);
        rmw_new = rmw_sat ? COUNT_MAX : rmw_old + COUNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rmw_vld_q  <= 1'b0;
            rmw_addr_q <= '0;
            fwd_vld_q  <= 1'b0;
            fwd_addr_q <= '0;
            fwd_data_q <= '0;
        end else begin
            rmw_vld_q  <= pix_acc;
            rmw_addr_q <= pix_in;
            fwd_vld_q  <= rmw_vld_q;
            fwd_addr_q <= rmw_addr_q;
            fwd_data_q <= rmw_new;
        end
    end

    // Scan: cnt_q issues reads 0..NUM_BINS-1; the bin read last cycle is summed now.
    assign scan_issue    = (state_q == ST_SCAN) && (cnt_q != CNT_SCAN_END);
    assign scan_stage    = (state_q == ST_SCAN) && (cnt_q != '0);
    assign scan_last     = (state_q == ST_SCAN) && (cnt_q == CNT_SCAN_END);
    assign scan_enter    = (state_q == ST_DRAIN) && (cnt_q == CNT_DRAIN_END);
    assign scan_bin      = cnt_q[PIX_W-1:0] - PIX_W'(1);
    assign scan_sum_wide = {1'b0, acc_q} + {1'b0, hist_rdata};
    assign scan_sum      = scan_sum_wide[COUNT_W] ? COUNT_MAX : scan_sum_wide[COUNT_W-1:0];

    always_comb begin
        hist_re    = pix_acc;
        hist_raddr = pix_in;
        hist_we    = 1'b0;
        hist_waddr = rmw_addr_q;
        hist_wdata = rmw_new;
        if (scan_issue) begin
            hist_re    = 1'b1;
            hist_raddr = cnt_q[PIX_W-1:0];
        end
        if (rmw_vld_q) begin
            hist_we = 1'b1;
        end else if (state_q == ST_CLEAR) begin
            hist_we    = 1'b1;
            hist_waddr = cnt_q[PIX_W-1:0];
            hist_wdata = '0;
        end else if (scan_stage) begin
            hist_we    = 1'b1;
            hist_waddr = scan_bin;
            hist_wdata = '0;
        end
    end

    logic [COUNT_W-1:0] cdf_min_q, total_q;
    logic               cdf_valid_q, frame_done_q, overflow_q, cdf_data_vld_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q          <= '0;
            cdf_min_q      <= '0;
            total_q        <= '0;
            cdf_valid_q    <= 1'b0;
            frame_done_q   <= 1'b0;
            overflow_q     <= 1'b0;
            cdf_data_vld_q <= 1'b0;
        end else begin
            frame_done_q   <= scan_last;
            cdf_data_vld_q <= lut_rd;
            if (scan_enter) begin
                acc_q       <= '0;
                cdf_min_q   <= '0;
                cdf_valid_q <= 1'b0;
            end
            if (scan_stage) begin
                acc_q <= scan_sum;
                // Running sum is monotonic, so zero means "not found yet".
                if ((cdf_min_q == '0) && (scan_sum != '0)) begin
                    cdf_min_q <= scan_sum;
                end
            end
            if (scan_last) begin
                total_q     <= scan_sum;
                cdf_valid_q <= 1'b1;
            end
            if ((rmw_vld_q && rmw_sat) || (scan_stage && scan_sum_wide[COUNT_W])) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign cdf_min      = cdf_min_q;
    assign total_pixels = total_q;
    assign cdf_valid    = cdf_valid_q;
    assign frame_done   = frame_done_q;
    assign overflow     = overflow_q;
    assign cdf_data_vld = cdf_data_vld_q;

endmodule

// File: tb/tb_histogram_cdf_builder.sv
module tb_histogram_cdf_builder;

    localparam longint unsigned MAX32 = 64'hFFFF_FFFF;
    localparam longint unsigned MAX4  = 64'd15;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pix_in;
    logic        pix_valid, pix_eof, pix_ready;
    logic        lut_rd;
    logic [7:0]  lut_addr;
    logic [31:0] cdf_data, cdf_min, total_pixels;
    logic        cdf_data_vld, cdf_valid, frame_done, overflow;

    logic        rst4;
    logic [7:0]  p4_in;
    logic        p4_valid, p4_eof, ready4;
    logic        rd4;
    logic [7:0]  addr4;
    logic [3:0]  data4, min4, total4;
    logic        dvld4, cvalid4, done4, ovf4;

    always #5 clk = ~clk;

    histogram_cdf_builder #(.COUNT_W(32), .PIX_W(8)) dut (
        .clk(clk), .reset(reset),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_eof(pix_eof), .pix_ready(pix_ready),
        .lut_rd(lut_rd), .lut_addr(lut_addr), .cdf_data(cdf_data), .cdf_data_vld(cdf_data_vld),
        .cdf_min(cdf_min), .total_pixels(total_pixels), .cdf_valid(cdf_valid),
        .frame_done(frame_done), .overflow(overflow)
    );

    histogram_cdf_builder #(.COUNT_W(4), .PIX_W(8)) dut4 (
        .clk(clk), .reset(rst4),
        .pix_in(p4_in), .pix_valid(p4_valid), .pix_eof(p4_eof), .pix_ready(ready4),
        .lut_rd(rd4), .lut_addr(addr4), .cdf_data(data4), .cdf_data_vld(dvld4),
        .cdf_min(min4), .total_pixels(total4), .cdf_valid(cvalid4),
        .frame_done(done4), .overflow(ovf4)
    );

    int n_checks = 0;
    int n_errors = 0;

    int              pix_q[$];
    longint unsigned model_cnt [256];
    longint unsigned exp_cdf   [256];
    longint unsigned exp_min, exp_total;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: CDF is the saturating running sum of saturated bin counts.
    task automatic model_finish(input longint unsigned maxv);
        longint unsigned acc, b;
        acc     = 0;
        exp_min = 0;
        for (int i = 0; i < 256; i++) begin
            b   = (model_cnt[i] > maxv) ? maxv : model_cnt[i];
            acc = acc + b;
            if (acc > maxv) acc = maxv;
            exp_cdf[i] = acc;
            if (exp_min == 0 && acc != 0) exp_min = acc;
        end
        exp_total = acc;
    endtask

    task automatic lut_read(input int a, output logic [31:0] v, output logic vld);
        lut_rd   = 1'b1;
        lut_addr = 8'(a);
        @(posedge clk); #1;
        lut_rd = 1'b0;
        v      = cdf_data;
        vld    = cdf_data_vld;
    endtask

    task automatic check_table(input string tag);
        logic [31:0] v;
        logic        vld;
        vld = 1'b0;
        for (int a = 0; a < 256; a++) begin
            lut_read(a, v, vld);
            check_val($sformatf("%s_cdf[%0d]", tag, a), v, exp_cdf[a]);
        end
        check_val({tag, "_rd_vld_hi"}, vld, 1);
        @(posedge clk); #1;
        check_val({tag, "_rd_vld_lo"}, cdf_data_vld, 0);
    endtask

    task automatic wait_ready(input string tag);
        int cyc;
        bit vld_seen;
        cyc      = 0;
        vld_seen = 0;
        while (!pix_ready && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            if (cdf_valid) vld_seen = 1;
        end
        check_val({tag, "_clear_len"}, cyc, 256);
        check_val({tag, "_valid_low"}, vld_seen, 0);
    endtask

    task automatic drive_pixels(input bit gaps);
        int not_ready, g;
        not_ready = 0;
        for (int i = 0; i < 256; i++) model_cnt[i] = 0;
        foreach (pix_q[k]) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) begin
                    pix_valid = 1'b0;
                    pix_eof   = 1'b0;
                    @(posedge clk); #1;
                end
            end
            pix_valid = 1'b1;
            pix_in    = 8'(pix_q[k]);
            pix_eof   = (k == pix_q.size() - 1);
            if (!pix_ready) not_ready++;
            model_cnt[pix_q[k]]++;
            @(posedge clk); #1;
        end
        pix_eof   = 1'b0;
        pix_valid = 1'b0;
        check_val("ready_in_accum", not_ready, 0);
    endtask

    task automatic finish_frame(input string tag, input bit hold);
        int pulses, ready_early;
        bit saw_invalid;
        pulses      = 0;
        ready_early = 0;
        saw_invalid = 0;
        pix_valid   = hold;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!cdf_valid) saw_invalid = 1;
            if (frame_done) begin
                pulses++;
                pix_valid = 1'b0;
            end else if (pulses == 0 && pix_ready) begin
                ready_early++;
            end
            if (pix_valid) pix_in = 8'($urandom);
        end
        pix_valid = 1'b0;
        @(posedge clk); #1;
        model_finish(MAX32);
        check_val({tag, "_done_pulses"}, pulses, 1);
        check_val({tag, "_ready_drain_scan"}, ready_early, 0);
        check_val({tag, "_valid_dropped"}, saw_invalid, 1);
        check_val({tag, "_cdf_valid"}, cdf_valid, 1);
        check_val({tag, "_cdf_min"}, cdf_min, exp_min);
        check_val({tag, "_total"}, total_pixels, exp_total);
        check_val({tag, "_overflow"}, overflow, 0);
        check_table(tag);
    endtask

    task automatic fill_random(input int n, input bit hot);
        pix_q.delete();
        for (int i = 0; i < n; i++) begin
            if (hot && $urandom_range(0, 1) == 1) pix_q.push_back($urandom_range(5, 6));
            else                                  pix_q.push_back($urandom_range(0, 255));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_pix_ready"}, pix_ready, 0);
        check_val({tag, "_cdf_data"}, cdf_data, 0);
        check_val({tag, "_cdf_data_vld"}, cdf_data_vld, 0);
        check_val({tag, "_cdf_min"}, cdf_min, 0);
        check_val({tag, "_total"}, total_pixels, 0);
        check_val({tag, "_cdf_valid"}, cdf_valid, 0);
        check_val({tag, "_frame_done"}, frame_done, 0);
        check_val({tag, "_overflow"}, overflow, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic        vld;
        int          pulses4;

        reset = 1'b1; rst4 = 1'b1;
        pix_in = '0; pix_valid = 1'b0; pix_eof = 1'b0; lut_rd = 1'b0; lut_addr = '0;
        p4_in = '0; p4_valid = 1'b0; p4_eof = 1'b0; rd4 = 1'b0; addr4 = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; rst4 = 1'b0;
        check_reset_outputs("rst");
        wait_ready("rst");

        // narrow counters: bin saturates at 15
        for (int i = 0; i < 20; i++) begin
            p4_valid = 1'b1; p4_in = 8'd3; p4_eof = (i == 19);
            @(posedge clk); #1;
        end
        p4_valid = 1'b0; p4_eof = 1'b0;
        pulses4 = 0;
        repeat (400) begin
            @(negedge clk);
            if (done4) pulses4++;
        end
        @(posedge clk); #1;
        check_val("w4_done_pulses", pulses4, 1);
        check_val("w4_overflow", ovf4, 1);
        check_val("w4_total", total4, MAX4);
        check_val("w4_cdf_min", min4, MAX4);
        check_val("w4_cdf_valid", cvalid4, 1);
        rd4 = 1'b1; addr4 = 8'd2;
        @(posedge clk); #1;
        check_val("w4_cdf[2]", data4, 0);
        addr4 = 8'd3;
        @(posedge clk); #1;
        check_val("w4_cdf[3]", data4, MAX4);
        addr4 = 8'd255;
        @(posedge clk); #1;
        check_val("w4_cdf[255]", data4, MAX4);
        rd4 = 1'b0;

        // frame A
        pix_q = '{10, 10, 20, 255};
        drive_pixels(1'b0);
        finish_frame("A", 1'b0);
        lut_read(9, v, vld);   check_val("A_lut9", v, 0);
        lut_read(10, v, vld);  check_val("A_lut10", v, 2);
        lut_read(20, v, vld);  check_val("A_lut20", v, 3);
        lut_read(255, v, vld); check_val("A_lut255", v, 4);
        check_val("A_min_const", cdf_min, 2);
        check_val("A_total_const", total_pixels, 4);

        // frame B: long same-bin burst then alternating bins
        pix_q.delete();
        for (int i = 0; i < 1000; i++) pix_q.push_back(7);
        for (int i = 0; i < 10; i++) pix_q.push_back((i % 2 == 0) ? 7 : 8);
        drive_pixels(1'b0);
        finish_frame("B", 1'b0);
        lut_read(7, v, vld); check_val("B_lut7", v, 1005);
        lut_read(8, v, vld); check_val("B_lut8", v, 1010);
        check_val("B_total_const", total_pixels, 1010);

        // frame C: random with gaps and hot bins, pixels offered through DRAIN/SCAN
        fill_random($urandom_range(150, 300), 1'b1);
        drive_pixels(1'b1);
        finish_frame("C", 1'b1);

        // frame D: single pixel; everything from C must be gone
        pix_q = '{0};
        drive_pixels(1'b0);
        finish_frame("D", 1'b0);
        check_val("D_min_const", cdf_min, 1);
        check_val("D_total_const", total_pixels, 1);

        // frame E: reset lands at scan address 100
        fill_random($urandom_range(100, 200), 1'b0);
        drive_pixels(1'b0);
        repeat (102) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("midscan");
        @(posedge clk); #1;
        reset = 1'b0;
        wait_ready("midscan");

        // frame F: fresh frame after the aborted scan
        fill_random($urandom_range(200, 400), 1'b1);
        drive_pixels(1'b1);
        finish_frame("F", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
